// File: rtl/updown_counter_display.sv
// updown_counter_display
//   Loadable WIDTH-bit up/down counter with button edge detection, wrap or
//   saturate at the ends, a continuous-run mode that stops STOP_MARGIN short
//   of the top, and a multiplexed active-low 7-segment display driver.
//
// Ports
//   clk_i      counter clock
//   greset     synchronous active-high reset
//   up_btn_i   increment button level (debounced)
//   dw_btn_i   decrement button level (debounced)
//   ld_btn_i   load button level (debounced)
//   run_i      continuous increment enable
//   din_i      load value
//   digsel_i   one-cycle strobe advancing the displayed digit
//   q_o        counter value
//   utc_o      q_o is all ones
//   dtc_o      q_o is zero
//   an_o       digit anodes, active-low
//   seg_o      segments {g..a}, active-low
//   dp_o       decimal point, held off
module updown_counter_display #(
    parameter int WIDTH       = 16,
    parameter int WRAP_EN     = 1,
    parameter int STOP_MARGIN = 4,
    parameter int BLANK_LZ    = 0
) (
    input  logic                  clk_i,
    input  logic                  greset,
    input  logic                  up_btn_i,
    input  logic                  dw_btn_i,
    input  logic                  ld_btn_i,
    input  logic                  run_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  digsel_i,
    output logic [WIDTH-1:0]      q_o,
    output logic                  utc_o,
    output logic                  dtc_o,
    output logic [WIDTH/4-1:0]    an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o
);

    localparam int DIGITS = WIDTH / 4;

    // Run limit computed one bit wider so 2^WIDTH itself is representable.
    localparam logic [WIDTH:0] FULL_RANGE = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] RUN_LIMIT  = FULL_RANGE - (WIDTH+1)'(STOP_MARGIN);

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              up_q, up_d;
    logic              dw_q, dw_d;
    logic              ld_q, ld_d;
    logic [DIGITS-1:0] ring_q, ring_d;

    logic up_rise, dw_rise, ld_rise;
    logic conflict;
    logic inc;

    always_comb begin
        up_d = up_btn_i;
        dw_d = dw_btn_i;
        ld_d = ld_btn_i;

        up_rise = up_btn_i & ~up_q;
        dw_rise = dw_btn_i & ~dw_q;
        ld_rise = ld_btn_i & ~ld_q;

        // Any two button levels high together suppresses all counting.
        conflict = (up_btn_i & dw_btn_i) | (up_btn_i & ld_btn_i) | (dw_btn_i & ld_btn_i);

        inc = up_rise | (run_i & ({1'b0, cnt_q} < RUN_LIMIT));

        cnt_d = cnt_q;
        if (!conflict) begin
            if (ld_rise) begin
                cnt_d = din_i;
            end else if (dw_rise) begin
                if (cnt_q == '0) begin
                    cnt_d = (WRAP_EN != 0) ? '1 : '0;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end else if (inc) begin
                if (cnt_q == '1) begin
                    cnt_d = (WRAP_EN != 0) ? '0 : '1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end

        ring_d = ring_q;
        if (digsel_i) begin
            ring_d = {ring_q[DIGITS-2:0], ring_q[DIGITS-1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (greset) begin
            cnt_q  <= '0;
            up_q   <= 1'b0;
            dw_q   <= 1'b0;
            ld_q   <= 1'b0;
            ring_q <= DIGITS'(1);
        end else begin
            cnt_q  <= cnt_d;
            up_q   <= up_d;
            dw_q   <= dw_d;
            ld_q   <= ld_d;
            ring_q <= ring_d;
        end
    end

    assign q_o   = cnt_q;
    assign utc_o = &cnt_q;
    assign dtc_o = ~|cnt_q;
    assign dp_o  = 1'b1;

    logic [3:0]        nib;
    logic [DIGITS-1:0] upper_nz;
    logic              acc_nz;

    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (ring_q[k]) begin
                nib = cnt_q[4*k +: 4];
            end
        end

        // upper_nz[k]: some nibble at position k or above is nonzero.
        acc_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc_nz      = acc_nz | (|cnt_q[4*k +: 4]);
            upper_nz[k] = acc_nz;
        end

        for (int k = 0; k < DIGITS; k++) begin
            an_o[k] = ~ring_q[k] | ((BLANK_LZ != 0) && (k != 0) && !upper_nz[k]);
        end

        case (nib)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: tb/tb_updown_counter_display.sv
module tb_updown_counter_display;

    localparam int S_QDEF   = 0;
    localparam int S_QSAT   = 1;
    localparam int S_QSM1   = 2;
    localparam int S_ANDEF  = 3;
    localparam int S_SEGDEF = 4;
    localparam int S_FLDEF  = 5;
    localparam int S_FLSAT  = 6;
    localparam int S_QW24   = 7;
    localparam int S_ANW24  = 8;
    localparam int S_SEGW24 = 9;
    localparam int S_DPDEF  = 10;

    logic clk = 1'b0;
    logic greset, up_btn, dw_btn, ld_btn, run, digsel;
    logic [15:0] din16;
    logic [23:0] din24;

    logic [15:0] q_def, q_sat, q_sm1;
    logic [23:0] q_w24;
    logic        utc_def, dtc_def, utc_sat, dtc_sat, utc_sm1, dtc_sm1, utc_w24, dtc_w24;
    logic [3:0]  an_def, an_sat, an_sm1;
    logic [5:0]  an_w24;
    logic [6:0]  seg_def, seg_sat, seg_sm1, seg_w24;
    logic        dp_def, dp_sat, dp_sm1, dp_w24;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    int          sig_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    updown_counter_display u_def (
        .clk_i(clk), .greset(greset), .up_btn_i(up_btn), .dw_btn_i(dw_btn),
        .ld_btn_i(ld_btn), .run_i(run), .din_i(din16), .digsel_i(digsel),
        .q_o(q_def), .utc_o(utc_def), .dtc_o(dtc_def), .an_o(an_def),
        .seg_o(seg_def), .dp_o(dp_def));

    updown_counter_display #(.WRAP_EN(0)) u_sat (
        .clk_i(clk), .greset(greset), .up_btn_i(up_btn), .dw_btn_i(dw_btn),
        .ld_btn_i(ld_btn), .run_i(run), .din_i(din16), .digsel_i(digsel),
        .q_o(q_sat), .utc_o(utc_sat), .dtc_o(dtc_sat), .an_o(an_sat),
        .seg_o(seg_sat), .dp_o(dp_sat));

    updown_counter_display #(.STOP_MARGIN(1)) u_sm1 (
        .clk_i(clk), .greset(greset), .up_btn_i(up_btn), .dw_btn_i(dw_btn),
        .ld_btn_i(ld_btn), .run_i(run), .din_i(din16), .digsel_i(digsel),
        .q_o(q_sm1), .utc_o(utc_sm1), .dtc_o(dtc_sm1), .an_o(an_sm1),
        .seg_o(seg_sm1), .dp_o(dp_sm1));

    updown_counter_display #(.WIDTH(24), .BLANK_LZ(1)) u_w24 (
        .clk_i(clk), .greset(greset), .up_btn_i(up_btn), .dw_btn_i(dw_btn),
        .ld_btn_i(ld_btn), .run_i(run), .din_i(din24), .digsel_i(digsel),
        .q_o(q_w24), .utc_o(utc_w24), .dtc_o(dtc_w24), .an_o(an_w24),
        .seg_o(seg_w24), .dp_o(dp_w24));

    function automatic logic [31:0] observe(input int s);
        case (s)
            S_QDEF:   return {16'h0, q_def};
            S_QSAT:   return {16'h0, q_sat};
            S_QSM1:   return {16'h0, q_sm1};
            S_ANDEF:  return {28'h0, an_def};
            S_SEGDEF: return {25'h0, seg_def};
            S_FLDEF:  return {30'h0, utc_def, dtc_def};
            S_FLSAT:  return {30'h0, utc_sat, dtc_sat};
            S_QW24:   return {8'h0, q_w24};
            S_ANW24:  return {26'h0, an_w24};
            S_SEGW24: return {25'h0, seg_w24};
            S_DPDEF:  return {31'h0, dp_def};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int s, input logic [31:0] v);
        tag_q.push_back(tag);
        sig_q.push_back(s);
        exp_q.push_back(v);
    endtask

    // Advance one clock and retire every expectation queued for this edge.
    task automatic step();
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            chk(tag_q.pop_front(), observe(sig_q.pop_front()), exp_q.pop_front());
        end
    endtask

    task automatic load16(input logic [15:0] v);
        din16  = v;
        ld_btn = 1'b1;
        push("load", S_QDEF, {16'h0, v});
        step();
        ld_btn = 1'b0;
        step();
    endtask

    // Hex digit segment patterns {g..a}, active-low.
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    initial begin
        logic [3:0]  an_seq [4];
        logic [3:0]  dig_seq [4];
        logic [15:0] e16;
        logic [5:0]  an24_seq [6];
        logic [3:0]  dig24_seq [6];

        greset = 1'b1; up_btn = 1'b0; dw_btn = 1'b0; ld_btn = 1'b0;
        run = 1'b0; digsel = 1'b0; din16 = '0; din24 = '0;

        step();
        push("rst_q", S_QDEF, 32'h0);
        push("rst_an", S_ANDEF, 32'hE);
        push("rst_flags", S_FLDEF, 32'h1);
        push("rst_dp", S_DPDEF, 32'h1);
        push("rst_q24", S_QW24, 32'h0);
        push("rst_an24", S_ANW24, 32'h3E);
        step();
        greset = 1'b0;

        // Load 1234 and walk the display through all four digits.
        load16(16'h1234);
        push("d0_an", S_ANDEF, 32'hE);
        push("d0_seg", S_SEGDEF, {25'h0, seg_tab[4]});
        step();
        an_seq  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        dig_seq = '{4'h3, 4'h2, 4'h1, 4'h4};
        digsel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push("scan_an", S_ANDEF, {28'h0, an_seq[i]});
            push("scan_seg", S_SEGDEF, {25'h0, seg_tab[dig_seq[i]]});
            step();
        end
        digsel = 1'b0;

        // Top boundary: wrap vs saturate.
        load16(16'hFFFF);
        push("max_flags", S_FLDEF, 32'h2);
        step();
        up_btn = 1'b1;
        push("wrap_up", S_QDEF, 32'h0);
        push("wrap_flags", S_FLDEF, 32'h1);
        push("sat_up", S_QSAT, 32'hFFFF);
        push("sat_flags", S_FLSAT, 32'h2);
        push("sm1_wrap_up", S_QSM1, 32'h0);
        step();
        up_btn = 1'b0;
        step();

        // Bottom boundary.
        load16(16'h0000);
        dw_btn = 1'b1;
        push("sat_dw0", S_QSAT, 32'h0);
        push("sat_dw0_flags", S_FLSAT, 32'h1);
        push("wrap_dw0", S_QDEF, 32'hFFFF);
        step();
        dw_btn = 1'b0;
        step();

        // Continuous run stops at the margin.
        load16(16'hFFF0);
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            e16 = (i <= 12) ? 16'(16'hFFF0 + i) : 16'hFFFC;
            push("run_def", S_QDEF, {16'h0, e16});
            push("run_sat", S_QSAT, {16'h0, e16});
            e16 = (i <= 15) ? 16'(16'hFFF0 + i) : 16'hFFFF;
            push("run_sm1", S_QSM1, {16'h0, e16});
            step();
        end
        run = 1'b0;

        // Held button counts once; simultaneous buttons do nothing.
        load16(16'h0010);
        up_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push("up_held", S_QDEF, 32'h0011);
            step();
        end
        up_btn = 1'b0;
        step();
        up_btn = 1'b1; dw_btn = 1'b1;
        push("conflict", S_QDEF, 32'h0011);
        step();
        up_btn = 1'b0; dw_btn = 1'b0;
        push("release", S_QDEF, 32'h0011);
        step();
        dw_btn = 1'b1;
        push("dw_alone", S_QDEF, 32'h0010);
        step();
        dw_btn = 1'b0;
        step();

        // Down pre-empts run, then run resumes; reset mid-run.
        load16(16'h0100);
        run = 1'b1; dw_btn = 1'b1;
        push("dw_over_run", S_QDEF, 32'h00FF);
        step();
        dw_btn = 1'b0;
        push("run_resume0", S_QDEF, 32'h0100);
        step();
        push("run_resume1", S_QDEF, 32'h0101);
        step();
        greset = 1'b1; digsel = 1'b1;
        push("midrun_rst_q", S_QDEF, 32'h0);
        push("midrun_rst_an", S_ANDEF, 32'hE);
        step();
        greset = 1'b0; run = 1'b0; digsel = 1'b0;
        step();

        // Wide counter with leading-zero blanking.
        din24 = 24'h000A05; ld_btn = 1'b1;
        push("w24_load", S_QW24, 32'h000A05);
        step();
        ld_btn = 1'b0;
        push("w24_d0_an", S_ANW24, 32'h3E);
        push("w24_d0_seg", S_SEGW24, {25'h0, seg_tab[5]});
        step();
        an24_seq  = '{6'b111101, 6'b111011, 6'b111111, 6'b111111, 6'b111111, 6'b111110};
        dig24_seq = '{4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h5};
        digsel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push("w24_scan_an", S_ANW24, {26'h0, an24_seq[i]});
            if (an24_seq[i] != 6'b111111)
                push("w24_scan_seg", S_SEGW24, {25'h0, seg_tab[dig24_seq[i]]});
            step();
        end
        digsel = 1'b0;
        din24 = 24'h0; ld_btn = 1'b1;
        push("w24_zero_q", S_QW24, 32'h0);
        push("w24_zero_an", S_ANW24, 32'h3E);
        push("w24_zero_seg", S_SEGW24, {25'h0, seg_tab[0]});
        step();
        ld_btn = 1'b0; digsel = 1'b1;
        push("w24_zero_d1", S_ANW24, 32'h3F);
        step();
        digsel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_counter_display.md
Name: updown_counter_display

Overview:
- Parametrised loadable up/down counter with multiplexed 7-segment display driver.
- Generalises the fixed 16-bit/4-digit top level to WIDTH bits and WIDTH/4 digits.
- Adds: in-block edge detection, wrap or saturate mode, a configurable continuous-run stop margin, and optional leading-zero blanking.
- Sits below the board top level. Runs on the divided counter clock; takes a digit-select strobe from the clock block.

Parameters:
- WIDTH, 16: counter width in bits. Must be a multiple of 4 and at least 8. DIGITS = WIDTH/4.
- WRAP_EN, 1: 1 = wrap at both ends; 0 = saturate at max and at 0.
- STOP_MARGIN, 4: continuous run stops once count >= 2^WIDTH - STOP_MARGIN. Range 1..2^WIDTH-1.
- BLANK_LZ, 0: 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk_i, in, 1: counter clock.
- greset, in, 1: synchronous active-high reset.
- up_btn_i, in, 1: increment button (level, already debounced).
- dw_btn_i, in, 1: decrement button (level).
- ld_btn_i, in, 1: load button (level).
- run_i, in, 1: continuous-increment enable (level).
- din_i, in, WIDTH: load value.
- digsel_i, in, 1: one-cycle strobe that advances the display digit.
- q_o, out, WIDTH: counter value.
- utc_o, out, 1: high when q_o is all ones.
- dtc_o, out, 1: high when q_o == 0.
- an_o, out, DIGITS: anodes, active-low.
- seg_o, out, 7: segments {g..a}, active-low.
- dp_o, out, 1: decimal point, constant 1 (off).

Behaviour:
- Reset (greset sampled high at a clk_i edge):
  - q_o = 0.
  - Edge registers up_q, dw_q and ld_q cleared to 0.
  - Ring = one-hot digit 0, so an_o = ~1.
  - Reset overrides every other input in the same cycle.
- Edge detect:
  - For each button, rise = btn_i & ~btn_q; btn_q <= btn_i every cycle.
  - Counter effect happens on the same edge at which the rise is sampled, so q_o changes one cycle after the button goes high.
  - A button held across reset release counts as a rise on the first cycle after reset.
- Conflict rule:
  - If two or more of up/dw/ld are sampled high in a cycle, no up, down, load or run action occurs that cycle.
  - Edge registers still update.
- Priority when not in conflict: load > down > up/run.
  - Load: ld rise -> q_o <= din_i.
  - Down: dw rise -> q_o - 1.
  - Up: inc = up rise OR (run_i AND q_o < 2^WIDTH - STOP_MARGIN). If inc -> q_o + 1. An up rise and run in the same cycle add only 1.
  - run_i does not block down or load. A down or load edge pre-empts run for that cycle.
- Boundaries:
  - WRAP_EN=1: max+1 -> 0; 0-1 -> max.
  - WRAP_EN=0: max+1 -> max; 0-1 -> 0.
  - Run never reaches max unless STOP_MARGIN = 1.
- Flags: utc_o and dtc_o are combinational from the q_o register. They are mutually exclusive.
- Display:
  - The one-hot ring rotates from digit i to digit i+1 (mod DIGITS) on each clk_i edge with digsel_i=1.
  - greset holds the ring at digit 0.
  - an_o = ~ring.
  - seg_o = hex decode of nibble q_o[4k+3:4k] for the active digit k. Patterns:
    0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - BLANK_LZ=1: if k > index of the most significant nonzero nibble, that an_o bit is forced to 1. When q_o = 0, only digit 0 is shown.
  - The display path is combinational from ring and q_o; a q_o change appears on seg_o in the same cycle.

Test Plan:
1. Defaults; reset, then load din_i=16'h1234 with a single ld pulse -> q_o=1234 one cycle later. Sweep digsel_i -> an_o cycles 1110, 1101, 1011, 0111; seg_o shows 4, 3, 2, 1.
2. q_o=FFFF, up rise -> 0000 with dtc_o=1 (WRAP_EN=1). Same with WRAP_EN=0 -> stays FFFF with utc_o=1. q_o=0, down rise with WRAP_EN=0 -> stays 0000.
3. q_o=FFF0, run_i held 20 cycles -> increments once per cycle, stops at FFFC and holds. STOP_MARGIN=1 -> stops at FFFF.
4. up_btn_i held 10 cycles -> exactly +1. up and dw raised in the same cycle -> no change. Release both, then raise dw alone -> -1.
5. run_i held while a dw rise occurs at q_o=0100 -> that cycle q_o=00FF, then run resumes incrementing. greset mid-run -> q_o=0000 and an_o=1110 next cycle.
6. WIDTH=24, BLANK_LZ=1, load 0x000A05 -> digits 3..5 blanked (an bits forced 1), digits 0..2 show 5, 0, A. Load 0 -> only digit 0 lit, showing 0.
